// File: rtl/line_clear_ctrl.sv
// rtl/line_clear_ctrl.sv - line-clear sequencer for the 10x20 playfield
//
// Captures the board on start, scans rows bottom-to-top, removes each full
// row by shifting everything above it down one row, then strobes done with
// the compacted board and the number of removed lines.
//
// Optional feature macro: LINE_CLEAR_SCORE_EN (adds the score_add port).
//
// Ports:
//   clk        in   system clock, all state on rising edge
//   reset      in   synchronous active-high reset
//   start      in   request a clear pass, sampled only in IDLE
//   board_in   in   board to process, row r at [r*WIDTH +: WIDTH], row 0 = top
//   board_out  out  working/result board (registered)
//   lines      out  rows removed in the current/last pass (registered)
//   busy       out  high whenever the sequencer is not IDLE
//   done       out  one-cycle pulse, board_out/lines final
//   score_add  out  score increment for the pass (LINE_CLEAR_SCORE_EN only)

module line_clear_ctrl #(
    parameter int HEIGHT = 20,
    parameter int WIDTH  = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [HEIGHT*WIDTH-1:0]   board_in,
    output logic [HEIGHT*WIDTH-1:0]   board_out,
    output logic [4:0]                lines,
    output logic                      busy,
    output logic                      done
`ifdef LINE_CLEAR_SCORE_EN
    ,
    output logic [10:0]               score_add
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [4:0] ROW_BOTTOM = 5'(HEIGHT - 1);

    state_t                    state_q;
    logic [4:0]                row_q;
    logic [HEIGHT*WIDTH-1:0]   board_q;
    logic [4:0]                lines_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      row_full;
    logic [HEIGHT*WIDTH-1:0]   shift_d;

`ifdef LINE_CLEAR_SCORE_EN
    logic [10:0]               score_q;

    function automatic logic [10:0] score_of(input logic [4:0] n);
        case (n)
            5'd0:    score_of = 11'd0;
            5'd1:    score_of = 11'd40;
            5'd2:    score_of = 11'd100;
            5'd3:    score_of = 11'd300;
            default: score_of = 11'd1200;
        endcase
    endfunction

    assign score_add = score_q;
`endif

    assign board_out = board_q;
    assign lines     = lines_q;
    assign busy      = busy_q;
    assign done      = done_q;

    assign row_full = &board_q[int'(row_q)*WIDTH +: WIDTH];

    // Board with row_q removed: rows 1..row_q take the row above them,
    // row 0 is refilled empty, rows below row_q keep their contents.
    always_comb begin
        shift_d = board_q;
        shift_d[0 +: WIDTH] = '0;
        for (int k = 1; k < HEIGHT; k++) begin
            if (k <= int'(row_q)) begin
                shift_d[k*WIDTH +: WIDTH] = board_q[(k-1)*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            row_q   <= ROW_BOTTOM;
            board_q <= '0;
            lines_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef LINE_CLEAR_SCORE_EN
            score_q <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        board_q <= board_in;
                        row_q   <= ROW_BOTTOM;
                        lines_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SCAN;
`ifdef LINE_CLEAR_SCORE_EN
                        score_q <= '0;
`endif
                    end
                end
                ST_SCAN: begin
                    if (row_full) begin
                        // Row pointer stays put: the row that dropped into
                        // this slot must be checked as well.
                        board_q <= shift_d;
                        lines_q <= lines_q + 5'd1;
                    end else if (row_q != 5'd0) begin
                        row_q <= row_q - 5'd1;
                    end else begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
`ifdef LINE_CLEAR_SCORE_EN
                        // lines_q is already final here, so the increment is
                        // presented together with the done strobe.
                        score_q <= score_of(lines_q);
`endif
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    row_q   <= ROW_BOTTOM;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// tb/tb_line_clear_ctrl.sv - scoreboard bench for line_clear_ctrl

module tb_line_clear_ctrl;

    localparam int H  = 20;
    localparam int W  = 10;
    localparam int NB = H * W;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [NB-1:0]   board_in;
    logic [NB-1:0]   board_out;
    logic [4:0]      lines;
    logic            busy;
    logic            done;
`ifdef LINE_CLEAR_SCORE_EN
    logic [10:0]     score_add;
`endif

    line_clear_ctrl #(.HEIGHT(H), .WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .board_in  (board_in),
        .board_out (board_out),
        .lines     (lines),
        .busy      (busy),
        .done      (done)
`ifdef LINE_CLEAR_SCORE_EN
        ,
        .score_add (score_add)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NB-1:0] board;
        int            n_lines;
        int            latency;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check_eq(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: keep non-full rows in order, pack them at the bottom.
    function automatic void model(input logic [NB-1:0] b, output logic [NB-1:0] o, output int n);
        int dst;
        logic [W-1:0] r;
        o   = '0;
        n   = 0;
        dst = H - 1;
        for (int src = H - 1; src >= 0; src--) begin
            r = b[src*W +: W];
            if (r == {W{1'b1}}) n++;
            else begin
                o[dst*W +: W] = r;
                dst--;
            end
        end
    endfunction

    function automatic int score_ref(input int n);
        if (n == 0) return 0;
        if (n == 1) return 40;
        if (n == 2) return 100;
        if (n == 3) return 300;
        return 1200;
    endfunction

    function automatic logic [NB-1:0] set_row(input logic [NB-1:0] b, input int r, input logic [W-1:0] v);
        logic [NB-1:0] t;
        t = b;
        t[r*W +: W] = v;
        return t;
    endfunction

    // One pass: push the expectation, accept start at edge 0, then walk the
    // cycles until done. mid_start_cyc > 0 pulses start while busy.
    task automatic run_pass(input string tag, input logic [NB-1:0] b, input int mid_start_cyc);
        exp_t e, got;
        int   cyc;
        model(b, e.board, e.n_lines);
        e.latency = H + 1 + e.n_lines;
        exp_q.push_back(e);
        board_in = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        board_in = '0;
        cyc = 1;
        while (!done && cyc < 100) begin
            if (busy !== 1'b1) check_eq({tag, " busy"}, NB'(busy), NB'(1));
            start = (cyc == mid_start_cyc);
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        got = exp_q.pop_front();
        check_eq({tag, " latency"}, NB'(cyc), NB'(got.latency));
        check_eq({tag, " lines"},   NB'(lines), NB'(got.n_lines));
        check_eq({tag, " board"},   board_out, got.board);
        check_eq({tag, " busy@done"}, NB'(busy), NB'(1));
`ifdef LINE_CLEAR_SCORE_EN
        check_eq({tag, " score"}, NB'(score_add), NB'(score_ref(got.n_lines)));
`endif
        // start in the done cycle must be ignored
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq({tag, " idle busy"}, NB'(busy), NB'(0));
        check_eq({tag, " idle done"}, NB'(done), NB'(0));
        check_eq({tag, " hold lines"}, NB'(lines), NB'(got.n_lines));
    endtask

    initial begin
        logic [NB-1:0] b;
        logic [W-1:0]  r;
        int            saw_done;

        reset    = 1'b1;
        start    = 1'b0;
        board_in = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("rst board", board_out, '0);
        check_eq("rst lines", NB'(lines), NB'(0));
        check_eq("rst busy",  NB'(busy), NB'(0));
        check_eq("rst done",  NB'(done), NB'(0));
`ifdef LINE_CLEAR_SCORE_EN
        check_eq("rst score", NB'(score_add), NB'(0));
`endif

        run_pass("empty", '0, 0);

        b = set_row('0, 19, 10'h3FF);
        b = set_row(b, 18, 10'b0000000001);
        run_pass("row19", b, 0);

        b = '0;
        b = set_row(b, 19, 10'h3FF);
        b = set_row(b, 17, 10'h3FF);
        b = set_row(b, 16, 10'h3FF);
        b = set_row(b, 15, 10'h3FF);
        b = set_row(b, 18, 10'b1010101010);
        run_pass("four", b, 0);

        run_pass("full", {NB{1'b1}}, 0);

        run_pass("row0", set_row('0, 0, 10'h3FF), 5);

        for (int t = 0; t < 4; t++) begin
            b = '0;
            for (int k = 0; k < H; k++) begin
                r = W'($urandom);
                if ($urandom_range(0, 2) == 0) r = '1;
                b = set_row(b, k, r);
            end
            run_pass($sformatf("rand%0d", t), b, 0);
        end

        // Reset in cycle 10 of a pass with row 19 full.
        board_in = set_row('0, 19, 10'h3FF);
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        board_in = '0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("mid rst busy",  NB'(busy), NB'(0));
        check_eq("mid rst board", board_out, '0);
        check_eq("mid rst lines", NB'(lines), NB'(0));
        saw_done = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) saw_done = 1;
            @(posedge clk); #1;
        end
        check_eq("mid rst no done", NB'(saw_done), NB'(0));

        b = set_row('0, 19, 10'h3FF);
        b = set_row(b, 10, 10'b1100110011);
        run_pass("after rst", b, 0);

        check_eq("queue empty", NB'(exp_q.size()), NB'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
